// File: rtl/frame_ctrl_pkg.sv
// Shared types and widths for the frame_ctrl double-buffer controller.
package frame_ctrl_pkg;

  localparam int unsigned STATE_W = 2;
  localparam int unsigned CNT_W   = 8;

  typedef enum logic [STATE_W-1:0] {
    S_ARM       = STATE_W'(0),
    S_CAPTURE   = STATE_W'(1),
    S_WAIT_SWAP = STATE_W'(2),
    S_FROZEN    = STATE_W'(3)
  } state_e;

endpackage

// File: rtl/frame_ctrl_if.sv
// Camera/display side signal bundle of frame_ctrl; slave = controller, master = environment.
interface frame_ctrl_if
  import frame_ctrl_pkg::*;
#(
  parameter int unsigned C_NB_IMG_PXLS = 14
);

  logic                     cap_we;
  logic [C_NB_IMG_PXLS-1:0] cap_addr;
  logic                     disp_frame_end;
  logic                     freeze;
  logic                     snap;
  logic                     wea0;
  logic                     wea1;
  logic                     rd_sel;
  logic                     addr_err;
  logic [STATE_W-1:0]       state_dbg;
  logic [CNT_W-1:0]         frames_done;
  logic [CNT_W-1:0]         frames_dropped;

  modport master (
    output cap_we, cap_addr, disp_frame_end, freeze, snap,
    input  wea0, wea1, rd_sel, addr_err, state_dbg, frames_done, frames_dropped
  );

  modport slave (
    input  cap_we, cap_addr, disp_frame_end, freeze, snap,
    output wea0, wea1, rd_sel, addr_err, state_dbg, frames_done, frames_dropped
  );

endinterface

// File: rtl/frame_ctrl_satcnt.sv
// Event counter that sticks at its all-ones value instead of wrapping.
module frame_ctrl_satcnt
  import frame_ctrl_pkg::*;
#(
  parameter int unsigned W = CNT_W
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_inc,
  output logic [W-1:0] o_cnt
);

  logic [W-1:0] r_cnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cnt <= '0;
    end else if (i_inc && (r_cnt != '1)) begin
      r_cnt <= r_cnt + W'(1);
    end
  end

  assign o_cnt = r_cnt;

endmodule

// File: rtl/frame_ctrl.sv
// Double-buffered camera frame controller with freeze/snap; statistics counters
// are built only when FRAME_CTRL_STATS_EN is defined.
module frame_ctrl
  import frame_ctrl_pkg::*;
#(
  parameter int unsigned C_IMG_PXLS    = 10800,
  parameter int unsigned C_NB_IMG_PXLS = 14
) (
  input  logic         clk,
  input  logic         rst,
  frame_ctrl_if.slave  bus
);

  localparam logic [C_NB_IMG_PXLS-1:0] LAST_ADDR = C_NB_IMG_PXLS'(C_IMG_PXLS - 1);

  state_e r_state;
  state_e w_state_nxt;
  logic   r_rd_sel;
  logic   r_snap_mode;
  logic   r_addr_err;

  logic   w_addr_zero;
  logic   w_addr_last;
  logic   w_addr_ok;
  logic   w_frame_start;
  logic   w_arm_go;
  logic   w_wr_en;
  logic   w_swap;
  logic   w_bad_wr;

  assign w_addr_zero   = (bus.cap_addr == '0);
  assign w_addr_last   = (bus.cap_addr == LAST_ADDR);
  assign w_addr_ok     = (32'(bus.cap_addr) < C_IMG_PXLS);
  assign w_frame_start = bus.cap_we && w_addr_zero;
  // A snap request overrides freeze for exactly one frame start.
  assign w_arm_go      = (r_state == S_ARM) && w_frame_start && (!bus.freeze || r_snap_mode);
  assign w_wr_en       = bus.cap_we && w_addr_ok && ((r_state == S_CAPTURE) || w_arm_go);
  assign w_swap        = (r_state == S_WAIT_SWAP) && bus.disp_frame_end;
  assign w_bad_wr      = (r_state == S_CAPTURE) && bus.cap_we && !w_addr_ok;

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_ARM;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state decode
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_ARM: begin
        if (w_arm_go) begin
          w_state_nxt = S_CAPTURE;
        end else if (w_frame_start) begin
          w_state_nxt = S_FROZEN;
        end
      end
      S_CAPTURE: begin
        if (w_wr_en && w_addr_last) begin
          w_state_nxt = S_WAIT_SWAP;
        end
      end
      S_WAIT_SWAP: begin
        if (w_swap) begin
          w_state_nxt = (bus.freeze || r_snap_mode) ? S_FROZEN : S_ARM;
        end
      end
      S_FROZEN: begin
        if (!bus.freeze || bus.snap) begin
          w_state_nxt = S_ARM;
        end
      end
      default: w_state_nxt = S_ARM;
    endcase
  end

  // Output decode: the write buffer is always the one not being displayed
  always_comb begin
    bus.wea0      = 1'b0;
    bus.wea1      = 1'b0;
    bus.state_dbg = r_state;
    if (w_wr_en) begin
      if (r_rd_sel) begin
        bus.wea0 = 1'b1;
      end else begin
        bus.wea1 = 1'b1;
      end
    end
  end

  // Buffer select, snap-mode and sticky error flags
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_rd_sel    <= 1'b0;
      r_snap_mode <= 1'b0;
      r_addr_err  <= 1'b0;
    end else begin
      if (w_swap) begin
        r_rd_sel <= ~r_rd_sel;
      end
      if (w_bad_wr) begin
        r_addr_err <= 1'b1;
      end
      if (r_state == S_FROZEN) begin
        if (!bus.freeze) begin
          r_snap_mode <= 1'b0;
        end else if (bus.snap) begin
          r_snap_mode <= 1'b1;
        end
      end
    end
  end

  assign bus.rd_sel   = r_rd_sel;
  assign bus.addr_err = r_addr_err;

`ifdef FRAME_CTRL_STATS_EN
  logic w_drop;

  // A new frame arriving while the finished one waits for display is lost.
  assign w_drop = (r_state == S_WAIT_SWAP) && w_frame_start;

  frame_ctrl_satcnt #(.W(CNT_W)) u_done_cnt (
    .clk   (clk),
    .rst   (rst),
    .i_inc (w_swap),
    .o_cnt (bus.frames_done)
  );

  frame_ctrl_satcnt #(.W(CNT_W)) u_drop_cnt (
    .clk   (clk),
    .rst   (rst),
    .i_inc (w_drop),
    .o_cnt (bus.frames_dropped)
  );
`else
  assign bus.frames_done    = '0;
  assign bus.frames_dropped = '0;
`endif

endmodule

// File: tb/tb_frame_ctrl.sv
// Self-checking bench for frame_ctrl: directed scenarios with literal expectations
// plus a randomized camera stream checked every cycle against a behavioural model.
module tb_frame_ctrl;

  localparam int unsigned IMG = 10800;
  localparam int unsigned NB  = 14;
`ifdef FRAME_CTRL_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  logic g_freeze;
  bit   chk_en;
  int   n_checks = 0;
  int   n_fail   = 0;
  int   obs_w0   = 0;
  int   obs_w1   = 0;

  // Behavioural model: phase follows the state_dbg numbering
  int m_phase;
  bit m_rd;
  bit m_snap;
  bit m_err;
  int m_done;
  int m_drop;

  always #5 clk = ~clk;

  frame_ctrl_if #(.C_NB_IMG_PXLS(NB)) bus ();

  frame_ctrl #(.C_IMG_PXLS(IMG), .C_NB_IMG_PXLS(NB)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endfunction

  function automatic int stat(input int v);
    return STATS ? v : 0;
  endfunction

  function automatic void model_reset();
    m_phase = 0;
    m_rd    = 1'b0;
    m_snap  = 1'b0;
    m_err   = 1'b0;
    m_done  = 0;
    m_drop  = 0;
  endfunction

  // True when the current camera pixel is accepted into the back buffer.
  function automatic bit model_write();
    bit in_range;
    bit start;
    in_range = 32'(bus.cap_addr) < IMG;
    start    = bus.cap_we && (bus.cap_addr == '0);
    if (!bus.cap_we || !in_range) return 1'b0;
    if (m_phase == 1) return 1'b1;
    return (m_phase == 0) && start && (!bus.freeze || m_snap);
  endfunction

  function automatic void model_step(input bit wr);
    bit start;
    start = bus.cap_we && (bus.cap_addr == '0);
    if (m_phase == 1 && bus.cap_we && 32'(bus.cap_addr) >= IMG) m_err = 1'b1;
    if (m_phase == 2 && start && m_drop < 255) m_drop++;
    case (m_phase)
      0: if (start) m_phase = wr ? 1 : 3;
      1: if (wr && 32'(bus.cap_addr) == IMG - 1) m_phase = 2;
      2: if (bus.disp_frame_end) begin
           m_rd = !m_rd;
           if (m_done < 255) m_done++;
           m_phase = (bus.freeze || m_snap) ? 3 : 0;
         end
      default: if (!bus.freeze) begin
                 m_phase = 0;
                 m_snap  = 1'b0;
               end else if (bus.snap) begin
                 m_phase = 0;
                 m_snap  = 1'b1;
               end
    endcase
  endfunction

  // Per-cycle comparison against the model, sampled on the falling edge
  always @(negedge clk) begin
    bit w;
    if (chk_en) begin
      if (!rst) model_reset();
      w = (rst === 1'b1) ? model_write() : 1'b0;
      chk("wea0", 32'(bus.wea0), 32'(w && m_rd));
      chk("wea1", 32'(bus.wea1), 32'(w && !m_rd));
      chk("rd_sel", 32'(bus.rd_sel), 32'(m_rd));
      chk("addr_err", 32'(bus.addr_err), 32'(m_err));
      chk("state_dbg", 32'(bus.state_dbg), 32'(m_phase));
      chk("frames_done", 32'(bus.frames_done), 32'(stat(m_done)));
      chk("frames_dropped", 32'(bus.frames_dropped), 32'(stat(m_drop)));
      if (rst) begin
        if (bus.wea0) obs_w0++;
        if (bus.wea1) obs_w1++;
        model_step(w);
      end
    end
  end

  task automatic step(input bit we, input int addr, input bit dfe, input bit sn);
    bus.cap_we         = we;
    bus.cap_addr       = NB'(addr);
    bus.disp_frame_end = dfe;
    bus.freeze         = g_freeze;
    bus.snap           = sn;
    @(posedge clk);
    #1;
  endtask

  task automatic stream(input int a0, input int a1);
    for (int a = a0; a <= a1; a++) step(1'b1, a, 1'b0, 1'b0);
  endtask

  task automatic clr_obs();
    obs_w0 = 0;
    obs_w1 = 0;
  endtask

  task automatic chk_state(input string name, input int st, input bit rd);
    chk({name, "_state"}, 32'(bus.state_dbg), 32'(st));
    chk({name, "_rd_sel"}, 32'(bus.rd_sel), 32'(rd));
  endtask

  initial begin
    int a;
    rst      = 1'b0;
    g_freeze = 1'b0;
    chk_en   = 1'b1;
    bus.cap_we = 1'b0; bus.cap_addr = '0; bus.disp_frame_end = 1'b0;
    bus.freeze = 1'b0; bus.snap = 1'b0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    chk_state("reset", 0, 1'b0);
    chk("reset_err", 32'(bus.addr_err), 32'd0);
    rst = 1'b1;

    // One full frame lands in buffer 1, then display swaps to it
    clr_obs();
    stream(0, IMG - 1);
    chk("f1_wea1_cnt", 32'(obs_w1), 32'd10800);
    chk("f1_wea0_cnt", 32'(obs_w0), 32'd0);
    chk_state("f1_done", 2, 1'b0);
    step(1'b0, 0, 1'b1, 1'b0);
    chk_state("f1_swap", 0, 1'b1);
    chk("f1_frames_done", 32'(bus.frames_done), 32'(stat(1)));

    // Last pixel coincides with display frame end: no swap yet
    clr_obs();
    stream(0, IMG - 2);
    step(1'b1, IMG - 1, 1'b1, 1'b0);
    step(1'b0, 0, 1'b0, 1'b0);
    chk("f2_wea0_cnt", 32'(obs_w0), 32'd10800);
    chk_state("f2_noswap", 2, 1'b1);

    // Frames arriving while waiting for swap are dropped, counter saturates
    clr_obs();
    for (int f = 0; f < 3; f++) stream(0, 19);
    chk("drop3_writes", 32'(obs_w0 + obs_w1), 32'd0);
    chk("drop3_cnt", 32'(bus.frames_dropped), 32'(stat(3)));
    for (int f = 0; f < 257; f++) step(1'b1, 0, 1'b0, 1'b0);
    chk("drop_sat", 32'(bus.frames_dropped), 32'(stat(255)));
    step(1'b0, 0, 1'b1, 1'b0);
    chk_state("f2_swap", 0, 1'b0);
    chk("f2_frames_done", 32'(bus.frames_done), 32'(stat(2)));

    // Freeze: display held across several camera frames
    g_freeze = 1'b1;
    clr_obs();
    step(1'b1, 0, 1'b0, 1'b0);
    chk_state("frz_enter", 3, 1'b0);
    for (int f = 0; f < 5; f++) begin
      stream(0, 49);
      step(1'b0, 0, 1'b1, 1'b0);
    end
    chk("frz_writes", 32'(obs_w0 + obs_w1), 32'd0);
    chk_state("frz_hold", 3, 1'b0);

    // Snap: exactly one frame captured and shown, then frozen again
    step(1'b0, 0, 1'b0, 1'b1);
    chk_state("snap_arm", 0, 1'b0);
    clr_obs();
    stream(0, IMG - 1);
    chk("snap_wea1_cnt", 32'(obs_w1), 32'd10800);
    chk("snap_wea0_cnt", 32'(obs_w0), 32'd0);
    step(1'b0, 0, 1'b1, 1'b0);
    chk_state("snap_swap", 3, 1'b1);
    chk("snap_frames_done", 32'(bus.frames_done), 32'(stat(3)));
    clr_obs();
    stream(0, 9);
    chk("snap_after_writes", 32'(obs_w0 + obs_w1), 32'd0);

    // Out-of-range address inside a frame
    g_freeze = 1'b0;
    step(1'b0, 0, 1'b0, 1'b0);
    chk_state("unfrz", 0, 1'b1);
    clr_obs();
    step(1'b1, 0, 1'b0, 1'b0);
    step(1'b1, 12000, 1'b0, 1'b0);
    chk("oor_writes", 32'(obs_w0 + obs_w1), 32'd1);
    repeat (3) step(1'b0, 0, 1'b0, 1'b0);
    chk("oor_err", 32'(bus.addr_err), 32'd1);
    chk_state("oor", 1, 1'b1);

    // Reset mid-frame discards the partial frame
    stream(1, 4999);
    bus.cap_we = 1'b1;
    bus.cap_addr = NB'(5000);
    rst = 1'b0;
    #1;
    chk("rst_wea0", 32'(bus.wea0), 32'd0);
    chk("rst_wea1", 32'(bus.wea1), 32'd0);
    chk_state("rst_mid", 0, 1'b0);
    chk("rst_err", 32'(bus.addr_err), 32'd0);
    chk("rst_done", 32'(bus.frames_done), 32'd0);
    chk("rst_drop", 32'(bus.frames_dropped), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b1;
    clr_obs();
    stream(5001, IMG - 1);
    chk("resume_writes", 32'(obs_w0 + obs_w1), 32'd0);
    step(1'b1, 0, 1'b0, 1'b0);
    chk("restart_wea1", 32'(obs_w1), 32'd1);
    chk_state("restart", 1, 1'b0);

    // Randomized camera stream with glitches, display pulses, freeze and snap
    a = 1;
    for (int c = 0; c < 26000; c++) begin
      bit we;
      bit dfe;
      bit sn;
      int addr;
      we   = $urandom_range(0, 99) < 92;
      dfe  = $urandom_range(0, 399) == 0;
      sn   = $urandom_range(0, 1499) == 0;
      if ($urandom_range(0, 3999) == 0) g_freeze = !g_freeze;
      if (we) begin
        case ($urandom_range(0, 2999))
          0: a = int'($urandom_range(0, 16383));
          1: a = 0;
          default: ;
        endcase
        addr = a;
        a = (a + 1 >= int'(IMG)) ? 0 : a + 1;
      end else begin
        addr = int'($urandom_range(0, 16383));
      end
      step(we, addr, dfe, sn);
    end

    chk_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
